// File: rtl/otter_pc_ctrl.sv
// otter_pc_ctrl: next-PC sequencer for the OTTER fetch stage.
// Chooses between boot vector, trap entry, MRET return, EX-stage redirect,
// hazard stall and sequential fetch. It also produces the pipeline flush
// window that follows every redirect and the IF-stage valid qualifier.
module otter_pc_ctrl #(
  parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic        PCC_CLK,
  input  logic        PCC_RST_N,
  input  logic [31:0] PCC_PC,
  input  logic        PCC_STALL,
  input  logic        PCC_BR_TAKEN,
  input  logic [31:0] PCC_BR_TGT,
  input  logic        PCC_TRAP,
  input  logic [31:0] PCC_MTVEC,
  input  logic        PCC_MRET,
  input  logic [31:0] PCC_MEPC,
  output logic        PCC_PC_LD,
  output logic [31:0] PCC_PC_DIN,
  output logic        PCC_FLUSH,
  output logic        PCC_IF_VALID,
  output logic [1:0]  PCC_STATE
);

  localparam int unsigned      CNT_W      = $clog2(FLUSH_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_redirect;
  logic [31:0]      w_redir_tgt;
  logic [31:0]      w_pc_inc;

  assign w_redirect = PCC_TRAP | PCC_MRET | PCC_BR_TAKEN;
  assign w_pc_inc   = PCC_PC + 32'd4;
  assign PCC_STATE  = r_state;

  // Redirect target: trap beats MRET beats branch; low bits cleared since
  // only word-aligned fetch exists (JALR may hand us an odd target).
  always_comb begin
    w_redir_tgt = PCC_BR_TGT;
    if (PCC_TRAP) begin
      w_redir_tgt = PCC_MTVEC;
    end else if (PCC_MRET) begin
      w_redir_tgt = PCC_MEPC;
    end
    w_redir_tgt[1:0] = 2'b00;
  end

  // State and flush counter; reset wins over anything in flight.
  always_ff @(posedge PCC_CLK) begin
    if (!PCC_RST_N) begin
      r_state <= ST_BOOT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic and PC load/flush/valid outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    PCC_PC_LD    = 1'b0;
    PCC_PC_DIN   = PCC_PC;
    PCC_FLUSH    = 1'b0;
    PCC_IF_VALID = 1'b0;
    case (r_state)
      ST_RUN, ST_FLUSH: begin
        if (w_redirect) begin
          // A stall alongside a redirect is dropped: the stalled
          // instruction is among those being flushed.
          PCC_PC_LD  = 1'b1;
          PCC_PC_DIN = w_redir_tgt;
          PCC_FLUSH  = 1'b1;
          if (FLUSH_DEPTH == 1) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = CNT_RELOAD;
          end
        end else if (PCC_STALL) begin
          // Hold PC; a stall inside the flush window freezes the count.
          PCC_FLUSH = (r_state == ST_FLUSH);
        end else begin
          PCC_PC_LD  = 1'b1;
          PCC_PC_DIN = w_pc_inc;
          if (r_state == ST_RUN) begin
            PCC_IF_VALID = 1'b1;
          end else begin
            PCC_FLUSH = 1'b1;
            if (r_cnt <= CNT_ONE) begin
              w_state_nxt = ST_RUN;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt - CNT_ONE;
            end
          end
        end
      end
      default: begin
        // BOOT, and the unused 2'b11 encoding which recovers through BOOT.
        PCC_PC_LD   = 1'b1;
        PCC_PC_DIN  = RESET_VEC;
        PCC_FLUSH   = 1'b1;
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_otter_pc_ctrl.sv
// Testbench for otter_pc_ctrl: directed cycle sequence, expected outputs
// queued per cycle and compared against the DUT while the clock is low.
module tb_otter_pc_ctrl;

  localparam logic [31:0] RST_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        stall, br, trap, mret;
  logic [31:0] br_tgt, mtvec, mepc;
  logic        pc_ld;
  logic [31:0] pc_din;
  logic        flush, if_valid;
  logic [1:0]  state;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string       tag;
    logic        ld;
    logic [31:0] din;
    logic        fl;
    logic        iv;
    logic [1:0]  st;
  } exp_t;

  exp_t sb_q[$];

  otter_pc_ctrl #(
    .RESET_VEC  (RST_VEC),
    .FLUSH_DEPTH(2)
  ) dut (
    .PCC_CLK     (clk),
    .PCC_RST_N   (rst_n),
    .PCC_PC      (pc),
    .PCC_STALL   (stall),
    .PCC_BR_TAKEN(br),
    .PCC_BR_TGT  (br_tgt),
    .PCC_TRAP    (trap),
    .PCC_MTVEC   (mtvec),
    .PCC_MRET    (mret),
    .PCC_MEPC    (mepc),
    .PCC_PC_LD   (pc_ld),
    .PCC_PC_DIN  (pc_din),
    .PCC_FLUSH   (flush),
    .PCC_IF_VALID(if_valid),
    .PCC_STATE   (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // One cycle: drive inputs on the falling edge, queue what the DUT must
  // show, compare, then let the rising edge advance state and the PC.
  task automatic step(input string tag, input logic r_n, input logic s, input logic b,
                      input logic t, input logic m, input logic e_ld,
                      input logic [31:0] e_din, input logic e_fl, input logic e_iv,
                      input logic [1:0] e_st);
    exp_t e, g;
    @(negedge clk);
    rst_n = r_n; stall = s; br = b; trap = t; mret = m;
    e.tag = tag; e.ld = e_ld; e.din = e_din; e.fl = e_fl; e.iv = e_iv; e.st = e_st;
    sb_q.push_back(e);
    #1;
    g = sb_q.pop_front();
    check({g.tag, ".ld"},    {31'd0, pc_ld},    {31'd0, g.ld});
    check({g.tag, ".din"},   pc_din,            g.din);
    check({g.tag, ".flush"}, {31'd0, flush},    {31'd0, g.fl});
    check({g.tag, ".ifv"},   {31'd0, if_valid}, {31'd0, g.iv});
    check({g.tag, ".state"}, {30'd0, state},    {30'd0, g.st});
    @(posedge clk);
    if (g.ld) pc = g.din;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; br = 1'b0; trap = 1'b0; mret = 1'b0;
    pc = 32'hDEAD_BEE0; br_tgt = 32'h0; mtvec = 32'h0000_0080; mepc = 32'h0000_1237;

    // reset held, then BOOT ignores trap/stall, then sequential fetch
    for (int i = 0; i < 3; i++) step("rst", 0, 0, 0, 0, 0, 1, RST_VEC, 1, 0, 2'b00);
    step("boot", 1, 1, 0, 1, 0, 1, RST_VEC, 1, 0, 2'b00);
    step("seq0", 1, 0, 0, 0, 0, 1, 32'h104, 0, 1, 2'b01);
    step("seq1", 1, 0, 0, 0, 0, 1, 32'h108, 0, 1, 2'b01);
    step("seq2", 1, 0, 0, 0, 0, 1, 32'h10C, 0, 1, 2'b01);

    // branch redirect with unaligned target, two-cycle flush window
    pc = 32'h200; br_tgt = 32'h343;
    step("br",    1, 0, 1, 0, 0, 1, 32'h340, 1, 0, 2'b01);
    step("brfl",  1, 0, 0, 0, 0, 1, 32'h344, 1, 0, 2'b10);
    step("brrun", 1, 0, 0, 0, 0, 1, 32'h348, 0, 1, 2'b01);

    // trap + mret + branch together: trap wins
    step("trio",  1, 0, 1, 1, 1, 1, 32'h080, 1, 0, 2'b01);
    // mret inside the flush window reloads the count
    step("fmret", 1, 0, 0, 0, 1, 1, 32'h1234, 1, 0, 2'b10);
    step("fstl",  1, 1, 0, 0, 0, 0, 32'h1234, 1, 0, 2'b10);
    step("fseq",  1, 0, 0, 0, 0, 1, 32'h1238, 1, 0, 2'b10);
    step("frun",  1, 0, 0, 0, 0, 1, 32'h123C, 0, 1, 2'b01);

    // stall holds PC, then stall + branch takes the branch
    pc = 32'h40; br_tgt = 32'h500;
    for (int i = 0; i < 3; i++) step("stall", 1, 1, 0, 0, 0, 0, 32'h40, 0, 0, 2'b01);
    step("stlbr", 1, 1, 1, 0, 0, 1, 32'h500, 1, 0, 2'b01);
    step("sbfl",  1, 0, 0, 0, 0, 1, 32'h504, 1, 0, 2'b10);

    // sequential wrap at the top of the address space
    pc = 32'hFFFF_FFFC;
    step("wrap",  1, 0, 0, 0, 0, 1, 32'h0, 0, 1, 2'b01);

    // mret beats branch; then reset while stalled in the flush window
    br_tgt = 32'h600;
    step("mretbr", 1, 0, 1, 0, 1, 1, 32'h1234, 1, 0, 2'b01);
    step("rstfl",  0, 1, 0, 0, 0, 0, 32'h1234, 1, 0, 2'b10);
    step("reboot", 1, 0, 0, 0, 0, 1, RST_VEC, 1, 0, 2'b00);
    step("rerun",  1, 0, 0, 0, 0, 1, 32'h104, 0, 1, 2'b01);
    br_tgt = 32'h700;
    step("rebr",   1, 0, 1, 0, 0, 1, 32'h700, 1, 0, 2'b01);
    step("rebrfl", 1, 0, 0, 0, 0, 1, 32'h704, 1, 0, 2'b10);
    step("rebrrn", 1, 0, 0, 0, 0, 1, 32'h708, 0, 1, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
